// File: rtl/exc_pkg.sv
// exc_pkg: shared state encoding, ESR codes and MRS selects for the exception controller.
package exc_pkg;
  typedef enum logic [2:0] {RUN, TAKE, HANDLER, RETURN, HALT} state_t;
  localparam logic [2:0] ESR_UNDEF        = 3'd1;
  localparam logic [2:0] ESR_IRQ          = 3'd2;
  localparam logic [2:0] ESR_ILLEGAL_ERET = 3'd3;
  localparam logic [2:0] ESR_NESTED       = 3'd4;
  localparam logic [1:0] MRS_ELR = 2'd0;
  localparam logic [1:0] MRS_ESR = 2'd1;
  localparam logic [1:0] MRS_ERR = 2'd2;
  localparam logic [63:0] VECTOR_ADDR_DEFAULT = 64'h0000_0000_0000_00D8;
endpackage

// File: rtl/sysreg_file.sv
// sysreg_file: ELR/ESR/ERR storage with separate context and syndrome write enables and the MRS read mux.
module sysreg_file
  import exc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ctx_we,
  input  logic            esr_we,
  input  logic [XLEN-1:0] elr_d,
  input  logic [XLEN-1:0] err_d,
  input  logic [2:0]      esr_d,
  input  logic [1:0]      sel,
  output logic [XLEN-1:0] elr,
  output logic [2:0]      esr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] err;
  always_ff @(posedge clk) begin
    if (reset) begin
      elr <= '0;
      err <= '0;
      esr <= '0;
    end else begin
      if (ctx_we) begin
        elr <= elr_d;
        err <= err_d;
      end
      if (esr_we) esr <= esr_d;
    end
  end
  always_comb
    rdata = sel == MRS_ELR ? elr :
            sel == MRS_ESR ? {{(XLEN-3){1'b0}}, esr} :
            sel == MRS_ERR ? err : '0;
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: exception/interrupt FSM capturing faulting context, redirecting fetch to the vector and back on ERET.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] VECTOR_ADDR = VECTOR_ADDR_DEFAULT[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic            not_an_instr_i,
  input  logic            eret_i,
  input  logic            irq_i,
  input  logic [1:0]      mrs_sel_i,
  output logic            irq_ack_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic            in_handler_o,
  output logic            halt_o,
  output logic [XLEN-1:0] sysreg_rdata_o
);
  state_t state, next;
  logic ctx_we, esr_we;
  logic [2:0] esr_d, esr;
  logic [XLEN-1:0] elr, err_d;
  always_ff @(posedge clk) state <= reset ? RUN : next;
  // An interrupt carries no instruction syndrome, so ERR is cleared for it
  assign err_d = (!not_an_instr_i && irq_i) ? '0 : {{(XLEN-32){1'b0}}, instr_i};
  always_comb begin
    next = state;
    ctx_we = 1'b0;
    esr_we = 1'b0;
    esr_d = ESR_UNDEF;
    case (state)
      RUN: if (valid_i && (not_an_instr_i || irq_i || eret_i)) begin
        next = TAKE;
        ctx_we = 1'b1;
        esr_we = 1'b1;
        esr_d = not_an_instr_i ? ESR_UNDEF : irq_i ? ESR_IRQ : ESR_ILLEGAL_ERET;
      end
      TAKE: next = HANDLER;
      HANDLER: if (valid_i && not_an_instr_i) begin
        next = HALT;
        esr_we = 1'b1;
        esr_d = ESR_NESTED;
      end else if (valid_i && eret_i) next = RETURN;
      RETURN: next = RUN;
      default: next = HALT;
    endcase
  end
  sysreg_file #(.XLEN(XLEN)) u_sysreg (
    .clk(clk), .reset(reset), .ctx_we(ctx_we), .esr_we(esr_we),
    .elr_d(pc_i), .err_d(err_d), .esr_d(esr_d), .sel(mrs_sel_i),
    .elr(elr), .esr(esr), .rdata(sysreg_rdata_o)
  );
  assign redirect_o    = state == TAKE || state == RETURN;
  assign redirect_pc_o = state == TAKE ? VECTOR_ADDR : state == RETURN ? elr : '0;
  assign flush_o       = redirect_o;
  assign irq_ack_o     = state == TAKE && esr == ESR_IRQ;
  assign in_handler_o  = state == HANDLER || state == RETURN;
  assign halt_o        = state == HALT;
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed test-plan steps then random traffic, all checked against a behavioural model.
module tb_exception_ctrl;
  localparam logic [63:0] VEC = 64'hD8;
  logic clk = 1'b0;
  logic reset = 1'b1, valid = 1'b0, nai = 1'b0, eret = 1'b0, irq = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] instr = '0;
  logic [1:0] sel = '0;
  logic irq_ack, redirect, flush, in_handler, halt;
  logic [63:0] redirect_pc, rdata;
  int errors = 0, checks = 0;
  logic [63:0] m_elr = '0, m_err = '0, m_rpc = '0;
  logic [2:0] m_esr = '0;
  bit m_redir = 0, m_ack = 0, m_hand = 0, m_halt = 0, m_to_hand = 0;

  exception_ctrl dut (
    .clk(clk), .reset(reset), .valid_i(valid), .pc_i(pc), .instr_i(instr),
    .not_an_instr_i(nai), .eret_i(eret), .irq_i(irq), .mrs_sel_i(sel),
    .irq_ack_o(irq_ack), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .flush_o(flush), .in_handler_o(in_handler), .halt_o(halt), .sysreg_rdata_o(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [1:0] s, input logic [63:0] exp, input string tag);
    sel = s;
    #1 chk(tag, rdata, exp);
  endtask

  // Drive one cycle: compare outputs with the model mid-cycle, then advance the model at the edge.
  task automatic step(input bit r, input bit v, input logic [63:0] p, input logic [31:0] ins,
                      input bit n, input bit e, input bit q, input logic [1:0] s);
    logic [63:0] exp_rd;
    reset = r; valid = v; pc = p; instr = ins; nai = n; eret = e; irq = q; sel = s;
    #1;
    exp_rd = s == 0 ? m_elr : s == 1 ? {61'b0, m_esr} : s == 2 ? m_err : 64'h0;
    chk("redirect", {63'b0, redirect}, {63'b0, m_redir});
    chk("redirect_pc", redirect_pc, m_redir ? m_rpc : 64'h0);
    chk("flush", {63'b0, flush}, {63'b0, m_redir});
    chk("irq_ack", {63'b0, irq_ack}, {63'b0, m_ack});
    chk("in_handler", {63'b0, in_handler}, {63'b0, m_hand});
    chk("halt", {63'b0, halt}, {63'b0, m_halt});
    chk("sysreg_rdata", rdata, exp_rd);
    @(posedge clk);
    if (r) begin
      m_elr = '0; m_err = '0; m_esr = '0; m_rpc = '0;
      m_redir = 0; m_ack = 0; m_hand = 0; m_halt = 0; m_to_hand = 0;
    end else if (m_halt) begin
    end else if (m_redir) begin
      m_hand = m_to_hand; m_redir = 0; m_ack = 0;
    end else if (!m_hand) begin
      if (v && (n || q || e)) begin
        m_elr = p;
        m_esr = n ? 3'd1 : q ? 3'd2 : 3'd3;
        m_err = (!n && q) ? 64'h0 : {32'b0, ins};
        m_redir = 1; m_rpc = VEC; m_ack = (m_esr == 3'd2); m_to_hand = 1;
      end
    end else if (v && n) begin
      m_esr = 3'd4; m_halt = 1; m_hand = 0;
    end else if (v && e) begin
      m_redir = 1; m_rpc = m_elr; m_to_hand = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    bit irq_l, a, v;
    @(posedge clk);
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // Undefined opcode in RUN
    step(0, 1, 64'h40, 32'hFFFF_FFFF, 1, 0, 0, 0);
    peek(0, 64'h40, "undef_elr");
    peek(1, 64'h1, "undef_esr");
    peek(2, 64'hFFFF_FFFF, "undef_err");
    chk("undef_redirect_pc", redirect_pc, 64'hD8);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 64'hD8, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Interrupt then ERET back to the preempted PC
    step(0, 1, 64'h80, 32'h1234, 0, 0, 1, 1);
    chk("irq_ack_pulse", {63'b0, irq_ack}, 64'h1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 64'hD8, 0, 0, 0, 0, 0);
    step(0, 1, 64'hDC, 0, 0, 1, 0, 0);
    chk("irq_return_pc", redirect_pc, 64'h80);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 64'h80, 0, 0, 0, 0, 0);
    // Simultaneous undef and irq: undef wins, irq taken after return
    step(0, 1, 64'h10, 32'hDEAD_BEEF, 1, 0, 1, 1);
    peek(1, 64'h1, "simul_esr");
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 64'hD8, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 64'h10, 0, 0, 0, 1, 2);
    peek(1, 64'h2, "pending_irq_esr");
    step(0, 0, 0, 0, 0, 0, 1, 2);
    step(0, 1, 64'hD8, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // ERET in RUN is illegal
    step(0, 1, 64'h20, 32'h0000_0E0E, 0, 1, 0, 0);
    peek(1, 64'h3, "illegal_eret_esr");
    peek(0, 64'h20, "illegal_eret_elr");
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Nested undef in handler halts
    step(0, 1, 64'hE0, 32'h5, 1, 1, 1, 1);
    peek(1, 64'h4, "nested_esr");
    peek(0, 64'h20, "nested_elr");
    chk("halt_set", {63'b0, halt}, 64'h1);
    for (int i = 0; i < 4; i++) step(0, 1, 64'h100, 0, i[0], ~i[0], 1, 2'(i));
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Reset during TAKE cancels the redirect
    step(0, 1, 64'h300, 32'h77, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_take_redirect", {63'b0, redirect}, 64'h0);
    peek(0, 64'h0, "reset_elr");
    peek(2, 64'h0, "reset_err");
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // Random traffic with a level irq held until acknowledged
    irq_l = 0;
    for (int i = 0; i < 800; i++) begin
      irq_l = irq_l | ($urandom_range(0, 9) == 0);
      a = m_ack;
      v = !m_redir && ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 7) == 0), v,
           {$urandom, $urandom}, $urandom, $urandom_range(0, 11) == 0,
           $urandom_range(0, 4) == 0, irq_l, 2'($urandom_range(0, 3)));
      if (a) irq_l = 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequential exception/interrupt controller that consumes the decode-stage flags (`NotAnInstr`, `ERet`) and an external interrupt request, and owns the system registers ELR, ESR and ERR. It captures the faulting context, redirects fetch to the exception vector, serves MRS reads of the system registers, and restores the PC on ERET. It sits between the main decoder and the PC/fetch logic.

## Interface
- `XLEN`, 64, datapath and PC width.
- `VECTOR_ADDR`, 64'h0000_0000_0000_00D8, exception handler entry PC.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  the decode-stage instruction is valid (not bubble/flushed).
- `pc_i`  in  XLEN  PC of the decode-stage instruction.
- `instr_i`  in  32  instruction word in decode.
- `not_an_instr_i`  in  1  decoder flag: undefined opcode.
- `eret_i`  in  1  decoder flag: ERET.
- `irq_i`  in  1  external interrupt request, level, held until acked.
- `mrs_sel_i`  in  2  system register select for MRS (0 ELR, 1 ESR, 2 ERR, 3 reads zero).
- `irq_ack_o`  out  1  one-cycle acknowledge of `irq_i`.
- `redirect_o`  out  1  fetch must load `redirect_pc_o` this cycle.
- `redirect_pc_o`  out  XLEN  redirect target.
- `flush_o`  out  1  squash fetch/decode instructions.
- `in_handler_o`  out  1  executing inside the handler.
- `halt_o`  out  1  fatal nested exception; core stops.
- `sysreg_rdata_o`  out  XLEN  combinational MRS read data.

## Operation
- States: RUN, TAKE, HANDLER, RETURN, HALT. Reset → RUN; ELR=ESR=ERR=0; all outputs 0.
- Events are sampled only when `valid_i`=1. Priority within one cycle: `not_an_instr_i` > `irq_i` > `eret_i`.
- RUN:
  - `not_an_instr_i` → ELR←pc_i, ESR←1 (UNDEF), ERR←{32'b0,instr_i}, go to TAKE.
  - else `irq_i` → ELR←pc_i (instruction preempted, re-executed after return), ESR←2 (IRQ), ERR←0, go to TAKE.
  - else `eret_i` outside the handler → ESR←3 (ILLEGAL_ERET), ELR←pc_i, ERR←{32'b0,instr_i}, go to TAKE.
- TAKE, one cycle:
  - `redirect_o`=1, `redirect_pc_o`=VECTOR_ADDR, `flush_o`=1.
  - `irq_ack_o`=1 iff ESR=2.
  - Go to HANDLER.
- HANDLER:
  - `in_handler_o`=1; `irq_i` is masked and stays pending.
  - `eret_i` → RETURN.
  - `not_an_instr_i` → HALT, with ESR←4 (NESTED) and ELR/ERR unchanged.
- RETURN, one cycle: `redirect_o`=1, `redirect_pc_o`=ELR, `flush_o`=1; go to RUN.
- HALT: `halt_o`=1 held; only `reset` exits.
- A pending `irq_i` in RUN right after RETURN is taken normally. `valid_i` is forced low by the pipeline while `flush_o`=1, so events in TAKE/RETURN are ignored by design.
- `sysreg_rdata_o` reflects register contents as they stand at the start of the cycle. ESR is zero-extended from its 3-bit code.

## Timing
- Event at decode in cycle N → `redirect_o`/`flush_o` asserted in cycle N+1, for exactly one cycle. The vector instruction is fetched in N+2.
- ELR/ESR/ERR update at the edge ending cycle N and are visible to MRS from cycle N+1.
- ERET in cycle M → return redirect in M+1; `in_handler_o` falls at the end of M+1.
- `irq_ack_o` is a single pulse coincident with the TAKE cycle.
- `reset` asserted in any state returns to RUN on the next edge: it clears the registers, drops all outputs, and discards any pending redirect.

## Structure
- Package `exc_pkg`:
  - state enum;
  - ESR codes (UNDEF=1, IRQ=2, ILLEGAL_ERET=3, NESTED=4);
  - `mrs_sel` encodings;
  - default `VECTOR_ADDR`.
- One natural sub-module, `sysreg_file`: holds ELR/ESR/ERR with a write-enable capture port and the MRS read mux. The FSM stays in `exception_ctrl`.

## Test plan
- Undefined opcode in RUN: pc_i=0x40, instr=0xFFFFFFFF, not_an_instr=1 → next cycle redirect to 0xD8 with flush=1; MRS ELR reads 0x40, ESR 1, ERR 0xFFFFFFFF.
- Interrupt: irq_i=1 at pc_i=0x80 → ack pulse and redirect to 0xD8. A later ERET in the handler → redirect to 0x80 with `in_handler_o` low afterwards.
- Simultaneous flags: not_an_instr=1 and irq_i=1 at pc 0x10 → ESR=1, no ack. After ERET, the still-pending irq is taken with ESR=2.
- ERET in RUN at pc 0x20 → ESR=3, ELR=0x20, redirect to 0xD8.
- Nested undefined instruction in HANDLER → `halt_o`=1, ESR=4, ELR unchanged. Halt persists until reset.
- Reset asserted during TAKE → next cycle redirect=0, state RUN, all system registers 0.
